// File: rtl/crc_frame_ctrl_pkg.sv
// Shared constants, types and the CRC-8 step function for the framing controller.
package crc_frame_ctrl_pkg;

  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_APPEND  = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  // One byte through an MSB-first, non-reflected CRC-8.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic [7:0] data,
                                           input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ({c[6:0], 1'b0} ^ poly) : {c[6:0], 1'b0};
    return c;
  endfunction

endpackage

// File: rtl/crc_frame_ctrl_crc8.sv
// Byte-wide CRC-8 accumulator; o_crc already includes a byte on the edge it is calculated.
module crc_8
  import crc_frame_ctrl_pkg::*;
#(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_arst_n,
  input  logic       i_init,
  input  logic       i_calc,
  input  logic [7:0] i_data,
  output logic [7:0] o_crc
);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n)   o_crc <= INIT;
    else if (i_init) o_crc <= INIT;
    else if (i_calc) o_crc <= crc8_step(o_crc, i_data, POLY);
  end

endmodule

// File: rtl/crc_frame_ctrl.sv
// Streams payload bytes through a one-deep output register and appends a CRC-8 byte per frame.
module crc_frame_ctrl
  import crc_frame_ctrl_pkg::*;
#(
  parameter logic [7:0] POLY    = 8'h07,
  parameter logic [7:0] INIT    = 8'h00,
  parameter int         MAX_LEN = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_abort,
  input  logic [7:0]  i_s_data,
  input  logic        i_s_valid,
  input  logic        i_s_last,
  output logic        o_s_ready,
  output logic [7:0]  o_m_data,
  output logic        o_m_valid,
  output logic        o_m_last,
  input  logic        i_m_ready,
  output logic        o_len_err,
  output logic [15:0] o_frame_cnt
);

  localparam cnt_t MAX_CNT = cnt_t'(MAX_LEN);

  state_t      state, state_n;
  cnt_t        byte_cnt, cnt_n, cnt_inc;
  logic [7:0]  data_n, crc;
  logic        valid_n, last_n, len_err_n;
  logic [15:0] fcnt_n;
  logic        crc_init, crc_calc, s_fire, m_fire, at_max;

  crc_8 #(.POLY(POLY), .INIT(INIT)) u_crc (
    .i_clk    (i_clk),
    .i_arst_n (1'b1),
    .i_init   (crc_init),
    .i_calc   (crc_calc),
    .i_data   (i_s_data),
    .o_crc    (crc)
  );

  assign cnt_inc = byte_cnt + 1'b1;
  assign at_max  = (cnt_inc == MAX_CNT);
  assign m_fire  = o_m_valid && i_m_ready;
  assign s_fire  = i_s_valid && o_s_ready;

  always_comb begin
    state_n   = state;
    data_n    = o_m_data;
    valid_n   = o_m_valid;
    last_n    = o_m_last;
    cnt_n     = byte_cnt;
    fcnt_n    = o_frame_cnt;
    len_err_n = 1'b0;
    o_s_ready = 1'b0;
    crc_init  = 1'b0;
    crc_calc  = 1'b0;
    // Abort wins over everything; ready is held low so no byte is handshaken and then lost.
    if (i_abort) begin
      valid_n = 1'b0;
      last_n  = 1'b0;
      cnt_n   = '0;
      state_n = ST_INIT;
    end else begin
      case (state)
        ST_INIT: begin
          crc_init = 1'b1;
          state_n  = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          o_s_ready = !o_m_valid || i_m_ready;
          if (s_fire) begin
            crc_calc = 1'b1;
            data_n   = i_s_data;
            valid_n  = 1'b1;
            last_n   = 1'b0;
            cnt_n    = cnt_inc;
            if (i_s_last || at_max) state_n = ST_APPEND;
            len_err_n = at_max && !i_s_last;
          end else if (m_fire) begin
            valid_n = 1'b0;
          end
        end
        ST_APPEND: begin
          if (!o_m_valid || i_m_ready) begin
            data_n  = crc;
            last_n  = 1'b1;
            valid_n = 1'b1;
            state_n = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (m_fire) begin
            valid_n = 1'b0;
            last_n  = 1'b0;
            fcnt_n  = o_frame_cnt + 16'd1;
            cnt_n   = '0;
            state_n = ST_INIT;
          end
        end
        default: state_n = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= ST_INIT;
      o_m_data    <= 8'h00;
      o_m_valid   <= 1'b0;
      o_m_last    <= 1'b0;
      o_len_err   <= 1'b0;
      o_frame_cnt <= 16'h0000;
      byte_cnt    <= '0;
    end else begin
      state       <= state_n;
      o_m_data    <= data_n;
      o_m_valid   <= valid_n;
      o_m_last    <= last_n;
      o_len_err   <= len_err_n;
      o_frame_cnt <= fcnt_n;
      byte_cnt    <= cnt_n;
    end
  end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Scoreboard bench for crc_frame_ctrl: a MAX_LEN=64 instance and a MAX_LEN=4 instance share stimulus.
module tb_crc_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, abort, s_valid, s_last, m_ready;
  logic [7:0]  s_data;
  logic        s_ready_a, m_valid_a, m_last_a, len_err_a;
  logic        s_ready_b, m_valid_b, m_last_b, len_err_b;
  logic [7:0]  m_data_a, m_data_b;
  logic [15:0] fcnt_a, fcnt_b;

  crc_frame_ctrl #(.POLY(8'h07), .INIT(8'h00), .MAX_LEN(64)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_abort(abort), .i_s_data(s_data),
    .i_s_valid(s_valid), .i_s_last(s_last), .o_s_ready(s_ready_a),
    .o_m_data(m_data_a), .o_m_valid(m_valid_a), .o_m_last(m_last_a),
    .i_m_ready(m_ready), .o_len_err(len_err_a), .o_frame_cnt(fcnt_a)
  );

  crc_frame_ctrl #(.POLY(8'h07), .INIT(8'h00), .MAX_LEN(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_abort(abort), .i_s_data(s_data),
    .i_s_valid(s_valid), .i_s_last(s_last), .o_s_ready(s_ready_b),
    .o_m_data(m_data_b), .o_m_valid(m_valid_b), .o_m_last(m_last_b),
    .i_m_ready(m_ready), .o_len_err(len_err_b), .o_frame_cnt(fcnt_b)
  );

  // sel picks which instance the driver and monitor observe
  logic        sel;
  logic        s_ready, m_valid, m_last, len_err;
  logic [7:0]  m_data;
  logic [15:0] fcnt;
  assign s_ready = sel ? s_ready_b : s_ready_a;
  assign m_valid = sel ? m_valid_b : m_valid_a;
  assign m_last  = sel ? m_last_b  : m_last_a;
  assign len_err = sel ? len_err_b : len_err_a;
  assign m_data  = sel ? m_data_b  : m_data_a;
  assign fcnt    = sel ? fcnt_b    : fcnt_a;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc8_ref(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    logic fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  typedef struct { logic [7:0] d; logic l; } exp_t;
  exp_t q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: always ready, 1: random, 2: never ready
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  logic [7:0] prev_d;
  logic       prev_l;
  logic       prev_stall = 1'b0;
  int         len_err_seen = 0;
  int         crc_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (prev_stall && m_valid) begin
        check("stall_data", m_data, prev_d);
        check("stall_last", m_last, prev_l);
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h last %0b, expected none", m_data, m_last);
        end else begin
          e = q.pop_front();
          check("m_data", m_data, e.d);
          check("m_last", m_last, e.l);
          if (m_last) crc_cyc = cyc;
        end
      end
      if (len_err) len_err_seen++;
    end
    prev_stall = m_valid && !m_ready;
    prev_d     = m_data;
    prev_l     = m_last;
  end

  logic [7:0] mcrc;
  int         mcnt, max_len, last_fire_cyc;

  task automatic send_byte(input logic [7:0] d, input logic l,
                           input logic use_exp, input logic [7:0] exp_crc);
    bit done;
    done    = 1'b0;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (s_ready) begin
        done = 1'b1;
        q.push_back('{d, 1'b0});
        mcrc = crc8_ref(mcrc, d);
        mcnt++;
        if (l || mcnt == max_len) begin
          q.push_back('{(use_exp ? exp_crc : mcrc), 1'b1});
          mcrc = 8'h00;
          mcnt = 0;
          last_fire_cyc = cyc;
        end
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout: byte %0h never accepted, expected accept", d);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !m_valid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct { logic [71:0] b; int n; logic [7:0] crc; } vec_t;
  vec_t tbl[4];

  initial begin
    tbl[0] = '{72'h39_38_37_36_35_34_33_32_31, 9, 8'hF4};
    tbl[1] = '{72'h01, 1, 8'h07};
    tbl[2] = '{72'h00, 1, 8'h00};
    tbl[3] = '{72'hFF, 1, 8'hF3};

    rst_n = 1'b0; abort = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    m_ready = 1'b1; sel = 1'b0; max_len = 64; mcrc = 8'h00; mcnt = 0; last_fire_cyc = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_len_err", len_err, 0);
    check("rst_frame_cnt", fcnt, 16'h0);
    check("rst_s_ready", s_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // table-driven frames, downstream always ready
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < tbl[i].n; j++)
        send_byte(tbl[i].b[8*j +: 8], (j == tbl[i].n - 1), 1'b1, tbl[i].crc);
      drain();
      check("crc_latency", crc_cyc - last_fire_cyc, 2);
      check("frame_cnt_tbl", fcnt, i + 1);
    end
    check("no_len_err", len_err_seen, 0);

    // random backpressure, same payload
    rdy_mode = 1;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 9; j++)
        send_byte(8'h31 + 8'(j), (j == 8), 1'b1, 8'hF4);
    rdy_mode = 0;
    drain();
    check("frame_cnt_bp", fcnt, 6);

    // abort after three bytes
    for (int j = 0; j < 3; j++) send_byte(8'h31 + 8'(j), 1'b0, 1'b0, 8'h00);
    drain();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    mcrc = 8'h00; mcnt = 0;
    @(negedge clk);
    check("abort_m_valid", m_valid, 0);
    check("abort_frame_cnt", fcnt, 6);
    for (int j = 0; j < 9; j++) send_byte(8'h31 + 8'(j), (j == 8), 1'b1, 8'hF4);
    drain();
    check("frame_cnt_abort", fcnt, 7);

    // reset while the CRC byte is waiting to be loaded
    rdy_mode = 2;
    @(posedge clk); #1;
    send_byte(8'hA5, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check("append_hold_valid", m_valid, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst2_m_valid", m_valid, 0);
    check("rst2_m_last", m_last, 0);
    check("rst2_m_data", m_data, 8'h00);
    check("rst2_frame_cnt", fcnt, 16'h0);
    check("rst2_s_ready", s_ready, 0);
    q.delete();
    mcrc = 8'h00; mcnt = 0;
    rdy_mode = 0;
    send_byte(8'h01, 1'b1, 1'b1, 8'h07);
    drain();
    check("frame_cnt_rst", fcnt, 1);

    // truncation on the MAX_LEN=4 instance
    sel = 1'b1;
    max_len = 4;
    len_err_seen = 0;
    for (int j = 0; j < 6; j++) send_byte(8'h10 + 8'(j), 1'b0, 1'b0, 8'h00);
    send_byte(8'h16, 1'b1, 1'b0, 8'h00);
    drain();
    check("len_err_pulses", len_err_seen, 1);
    check("frame_cnt_trunc", fcnt, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
